// File: rtl/dino_sprite_rom_if.sv
// rtl/dino_sprite_rom_if.sv - renderer/game-logic side bundle for the dino sprite ROM
interface dino_sprite_rom_if;
  logic [5:0] i_rom_counter;
  logic       o_sprite_color;
  logic       i_frame_tick;
  logic       i_jumping;
  logic       i_ducking;
  logic       i_game_over;
  logic [2:0] o_pose;

  // Renderer / game logic: drives address and player state, reads pixel and pose
  modport master (
    output i_rom_counter, i_frame_tick, i_jumping, i_ducking, i_game_over,
    input  o_sprite_color, o_pose
  );

  // Sprite ROM: responds with the pixel for the address in the current pose
  modport slave (
    input  i_rom_counter, i_frame_tick, i_jumping, i_ducking, i_game_over,
    output o_sprite_color, o_pose
  );
endinterface

// File: rtl/dino_sprite_rom.sv
// rtl/dino_sprite_rom.sv - dino sprite ROM with frame-synchronous pose FSM (option: DINO_ROM_REG_OUT_EN)
module dino_sprite_rom #(
  parameter int ANIM_TICKS = 6
) (
  input  logic              clk,
  input  logic              rst,
  dino_sprite_rom_if.slave  bus
);

  localparam logic [2:0] POSE_RUN_A  = 3'd0;
  localparam logic [2:0] POSE_RUN_B  = 3'd1;
  localparam logic [2:0] POSE_JUMP   = 3'd2;
  localparam logic [2:0] POSE_DUCK_A = 3'd3;
  localparam logic [2:0] POSE_DUCK_B = 3'd4;
  localparam logic [2:0] POSE_DEAD   = 3'd5;

  localparam logic [63:0] BMP_RUN_A  = 64'h0E171F1C9EFC7848;
  localparam logic [63:0] BMP_RUN_B  = 64'h0E171F1C9EFC7820;
  localparam logic [63:0] BMP_JUMP   = 64'h0E171F1C9EFC786C;
  localparam logic [63:0] BMP_DUCK_A = 64'h00000E1FFFFE7848;
  localparam logic [63:0] BMP_DUCK_B = 64'h00000E1FFFFE7820;
  localparam logic [63:0] BMP_DEAD   = 64'h0E151F1C9EFC7848;

  localparam logic [3:0] CNT_LAST = 4'(ANIM_TICKS - 1);

  logic [2:0]  pose_q, pose_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic [63:0] bitmap;
  logic        pixel;

  // Next pose/animation state; everything holds unless this cycle is a frame tick.
  // The next pose depends only on inputs and the animation counters, so the
  // unused codes 6/7 fall back into normal priority evaluation on the next tick.
  always_comb begin
    pose_d  = pose_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (bus.i_frame_tick) begin
      if (bus.i_game_over) begin
        pose_d  = POSE_DEAD;
        cnt_d   = 4'd0;
        phase_d = 1'b0;
      end else if (bus.i_jumping) begin
        pose_d  = POSE_JUMP;
        cnt_d   = 4'd0;
        phase_d = 1'b0;
      end else begin
        // run and duck share the leg counter so switching keeps legs in step
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 4'd0;
          phase_d = ~phase_q;
        end else begin
          cnt_d   = cnt_q + 4'd1;
        end
        if (bus.i_ducking) pose_d = phase_d ? POSE_DUCK_B : POSE_DUCK_A;
        else               pose_d = phase_d ? POSE_RUN_B  : POSE_RUN_A;
      end
    end
  end

  // Pose FSM and animation counters; reset returns to RUN_A immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pose_q  <= POSE_RUN_A;
      cnt_q   <= 4'd0;
      phase_q <= 1'b0;
    end else begin
      pose_q  <= pose_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Bitmap select for the current pose; unused codes show a blank sprite
  always_comb begin
    case (pose_q)
      POSE_RUN_A:  bitmap = BMP_RUN_A;
      POSE_RUN_B:  bitmap = BMP_RUN_B;
      POSE_JUMP:   bitmap = BMP_JUMP;
      POSE_DUCK_A: bitmap = BMP_DUCK_A;
      POSE_DUCK_B: bitmap = BMP_DUCK_B;
      POSE_DEAD:   bitmap = BMP_DEAD;
      default:     bitmap = 64'd0;
    endcase
  end

  // Row 0 lives in the top byte and col 0 in each byte's MSB
  assign pixel = bitmap[6'd63 - bus.i_rom_counter];

  assign bus.o_pose = pose_q;

`ifdef DINO_ROM_REG_OUT_EN
  // Registered read: pixel of last cycle's address and pose
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.o_sprite_color <= 1'b0;
    else     bus.o_sprite_color <= pixel;
  end
`else
  assign bus.o_sprite_color = pixel;
`endif

endmodule
